// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave frame controller: FSM encoding and
// the default log2 of the maximum frame length.
package spi_pkg;

  localparam int SPI_MAX_WIDTH_LOG_DEFAULT = 4;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

endpackage

// File: rtl/sck_detect.sv
// Edge detector for the synchronized SPI pins: chip-select start/finish
// events and SCK leading/trailing edges relative to the idle level (cpol).
module sck_detect #(
  parameter int SPI_MAX_WIDTH_LOG = spi_pkg::SPI_MAX_WIDTH_LOG_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpol,
  input  logic sck,
  input  logic cs,
  output logic spi_start,
  output logic spi_finish,
  output logic sck_first_edge,
  output logic sck_second_edge
);

  logic sck_q;
  logic cs_q;
  logic sck_toggle;

  if (SPI_MAX_WIDTH_LOG < 1 || SPI_MAX_WIDTH_LOG > 8) begin : g_bad_width
    $error("sck_detect: SPI_MAX_WIDTH_LOG must be in 1..8");
  end

  // cs_q resets high so the bus looks deselected until the pin is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q <= 1'b0;
      cs_q  <= 1'b1;
    end else begin
      sck_q <= sck;
      cs_q  <= cs;
    end
  end

  assign sck_toggle      = sck ^ sck_q;
  assign spi_start       = cs_q & ~cs;
  assign spi_finish      = ~cs_q & cs;
  // The first edge of a bit leaves the idle level, the second returns to it.
  assign sck_first_edge  = sck_toggle & (sck != cpol);
  assign sck_second_edge = sck_toggle & (sck == cpol);

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave frame controller: shifts MOSI into rx words, shifts a buffered
// tx word out on MISO, and repeats frames back-to-back while cs is low.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int SPI_MAX_WIDTH_LOG = SPI_MAX_WIDTH_LOG_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cpol,
  input  logic                           cpha,
  input  logic [SPI_MAX_WIDTH_LOG-1:0]   spi_width,
  input  logic                           sck,
  input  logic                           cs,
  input  logic                           mosi,
  output logic                           miso,
  output logic                           miso_oe,
  input  logic [2**SPI_MAX_WIDTH_LOG-1:0] tx_data,
  input  logic                           tx_valid,
  output logic                           tx_ready,
  output logic [2**SPI_MAX_WIDTH_LOG-1:0] rx_data,
  output logic                           rx_valid,
  output logic                           tx_underrun,
  output logic                           frame_abort,
  output logic                           busy
);

  localparam int DW = 2**SPI_MAX_WIDTH_LOG;

  logic [0:0]                   state;
  logic [SPI_MAX_WIDTH_LOG-1:0] bit_cnt;
  logic [DW-1:0]                tx_sh;
  logic [DW-1:0]                rx_sh;
  logic [DW-1:0]                tx_buf;
  logic                         tx_full;

  logic          spi_start, spi_finish, sck_first_edge, sck_second_edge;
  logic          active, sample, drive, word_done, load, accept;
  logic [DW-1:0] rx_next, width_mask;

  sck_detect #(.SPI_MAX_WIDTH_LOG(SPI_MAX_WIDTH_LOG)) u_sck_detect (
    .clk             (clk),
    .rst_n           (rst_n),
    .cpol            (cpol),
    .sck             (sck),
    .cs              (cs),
    .spi_start       (spi_start),
    .spi_finish      (spi_finish),
    .sck_first_edge  (sck_first_edge),
    .sck_second_edge (sck_second_edge)
  );

  assign active     = (state == ST_ACTIVE);
  assign sample     = active & (cpha ? sck_second_edge : sck_first_edge);
  assign drive      = active & (cpha ? sck_first_edge : sck_second_edge);
  assign word_done  = sample & (bit_cnt == spi_width);
  assign load       = (~active & spi_start) | word_done;
  assign accept     = tx_valid & ~tx_full;
  assign rx_next    = {rx_sh[DW-2:0], mosi};
  // ~spi_width equals (DW-1 - spi_width), leaving spi_width+1 ones.
  assign width_mask = {DW{1'b1}} >> (~spi_width);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (spi_start)  state <= ST_ACTIVE;
        ST_ACTIVE: if (spi_finish) state <= ST_IDLE;
        default:                   state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      tx_buf      <= '0;
      tx_full     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;

      if (sample) begin
        rx_sh   <= rx_next;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (word_done) begin
        rx_data  <= rx_next & width_mask;
        rx_valid <= 1'b1;
        bit_cnt  <= '0;
      end

      // The MSB of each word stays on the line until its first sample.
      if (drive && bit_cnt != '0) tx_sh <= tx_sh << 1;

      if (load) begin
        if (tx_full) begin
          tx_sh   <= tx_buf;
          tx_full <= 1'b0;
        end else begin
          tx_sh       <= '0;
          tx_underrun <= 1'b1;
        end
      end
      // NOTE: non-blocking updates make the last assignment win, so a
      // same-cycle accept overrides the load's clear while the load above
      // still read the pre-accept buffer contents.
      if (accept) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end

      if (active && spi_finish) begin
        bit_cnt <= '0;
        if (bit_cnt != '0 && !word_done) frame_abort <= 1'b1;
      end
    end
  end

  assign tx_ready = ~tx_full;
  assign busy     = active;
  assign miso_oe  = ~cs;
  assign miso     = miso_oe & tx_sh[spi_width];

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: a table of single-frame vectors over
// all modes and widths, plus hand sequences for multi-cycle corner cases.
module tb_spi_slave_ctrl;

  localparam int H = 4;  // SCK half period in clk cycles

  typedef struct {
    logic        cpol;
    logic        cpha;
    logic [3:0]  width;
    logic [15:0] tx;
    logic [15:0] mosi_word;
    logic [15:0] exp_rx;
    logic [15:0] exp_miso;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic [3:0]  spi_width = 4'd7;
  logic        sck = 1'b0;
  logic        cs = 1'b1;
  logic        mosi = 1'b0;
  logic [15:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_abort, busy;
  logic [15:0] rx_data;

  int n_checks = 0;
  int n_fail = 0;
  int rx_cnt = 0;
  int ur_cnt = 0;
  int ab_cnt = 0;
  logic [15:0] rx_log [64];

  spi_slave_ctrl #(.SPI_MAX_WIDTH_LOG(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpol        (cpol),
    .cpha        (cpha),
    .spi_width   (spi_width),
    .sck         (sck),
    .cs          (cs),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .frame_abort (frame_abort),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt % 64] = rx_data;
      rx_cnt++;
    end
    if (tx_underrun) ur_cnt++;
    if (frame_abort) ab_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input logic [15:0] w);
    int t;
    t = 0;
    while (!tx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("tx_ready_wait", tx_ready, 1);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Master side: clocks n bits of word (MSB = bit w-1) and captures MISO.
  task automatic spi_bits(input int w, input int n, input logic [15:0] word,
                          input bit cs_on_last, output logic [15:0] got);
    logic [15:0] wv;
    wv  = word;
    got = '0;
    for (int i = 0; i < n; i++) begin
      if (!cpha) begin
        mosi = wv[w-1-i];
        wait_clk(H);
        got = {got[14:0], miso};
        sck = ~cpol;
        if (cs_on_last && i == n - 1) begin
          cs = 1'b1;
        end else begin
          wait_clk(H);
          sck = cpol;
        end
      end else begin
        wait_clk(H);
        sck  = ~cpol;
        mosi = wv[w-1-i];
        wait_clk(H);
        got = {got[14:0], miso};
        sck = cpol;
      end
    end
  endtask

  task automatic frame_begin(input logic pol, input logic pha, input logic [3:0] wid);
    cpol      = pol;
    cpha      = pha;
    spi_width = wid;
    sck       = pol;
    wait_clk(2);
    cs = 1'b0;
    wait_clk(2);
  endtask

  task automatic frame_end();
    wait_clk(H);
    cs  = 1'b1;
    sck = cpol;
    wait_clk(3);
  endtask

  vec_t        vecs [7];
  logic [15:0] got, got2;
  int          rs, us, as;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 4'd7,  16'h00A5, 16'h003C, 16'h003C, 16'h00A5};
    vecs[1] = '{1'b0, 1'b1, 4'd7,  16'h0081, 16'h00C3, 16'h00C3, 16'h0081};
    vecs[2] = '{1'b1, 1'b0, 4'd11, 16'h0ABC, 16'h0123, 16'h0123, 16'h0ABC};
    vecs[3] = '{1'b1, 1'b1, 4'd15, 16'h8001, 16'hFFFF, 16'hFFFF, 16'h8001};
    vecs[4] = '{1'b0, 1'b0, 4'd0,  16'h0001, 16'h0001, 16'h0001, 16'h0001};
    vecs[5] = '{1'b0, 1'b0, 4'd15, 16'h7FFE, 16'h55AA, 16'h55AA, 16'h7FFE};
    vecs[6] = '{1'b1, 1'b0, 4'd3,  16'h00F9, 16'h0006, 16'h0006, 16'h0009};

    // Reset state
    wait_clk(3);
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_underrun", tx_underrun, 0);
    check("rst_frame_abort", frame_abort, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_ready", tx_ready, 1);
    rst_n = 1'b1;
    wait_clk(2);

    // Single-frame vectors; a filler word keeps the end-of-word load fed
    foreach (vecs[i]) begin
      rs = rx_cnt; us = ur_cnt; as = ab_cnt;
      tx_write(vecs[i].tx);
      frame_begin(vecs[i].cpol, vecs[i].cpha, vecs[i].width);
      tx_write(16'h5A5A);
      spi_bits(int'(vecs[i].width) + 1, int'(vecs[i].width) + 1, vecs[i].mosi_word, 1'b0, got);
      frame_end();
      check($sformatf("vec%0d_rx_count", i), rx_cnt - rs, 1);
      check($sformatf("vec%0d_rx_data", i), rx_log[rs % 64], vecs[i].exp_rx);
      check($sformatf("vec%0d_miso", i), got, vecs[i].exp_miso);
      check($sformatf("vec%0d_underrun", i), ur_cnt - us, 0);
      check($sformatf("vec%0d_abort", i), ab_cnt - as, 0);
    end

    // Mode 3 back-to-back words; the last word's load finds an empty buffer
    rs = rx_cnt; us = ur_cnt;
    tx_write(16'h1234);
    frame_begin(1'b1, 1'b1, 4'd15);
    tx_write(16'hBEEF);
    spi_bits(16, 16, 16'hCAFE, 1'b0, got);
    check("b2b_busy_mid", busy, 1);
    spi_bits(16, 16, 16'h0F0F, 1'b0, got2);
    frame_end();
    check("b2b_rx_count", rx_cnt - rs, 2);
    check("b2b_rx0", rx_log[rs % 64], 16'hCAFE);
    check("b2b_rx1", rx_log[(rs + 1) % 64], 16'h0F0F);
    check("b2b_miso0", got, 16'h1234);
    check("b2b_miso1", got2, 16'hBEEF);
    check("b2b_underrun", ur_cnt - us, 1);
    check("b2b_busy_end", busy, 0);

    // Empty buffer at cs fall, width 4
    rs = rx_cnt; us = ur_cnt;
    frame_begin(1'b0, 1'b0, 4'd3);
    tx_write(16'h0003);
    spi_bits(4, 4, 16'h000A, 1'b0, got);
    frame_end();
    check("ur_underrun", ur_cnt - us, 1);
    check("ur_miso", got, 16'h0000);
    check("ur_rx_data", rx_log[rs % 64], 16'h000A);
    check("ur_rx_count", rx_cnt - rs, 1);

    // cs rises after 5 of 8 bits, then a full frame
    rs = rx_cnt; as = ab_cnt;
    tx_write(16'h005A);
    frame_begin(1'b0, 1'b0, 4'd7);
    spi_bits(8, 5, 16'h00FF, 1'b0, got);
    frame_end();
    check("abort_pulse", ab_cnt - as, 1);
    check("abort_no_rx", rx_cnt - rs, 0);
    check("abort_busy", busy, 0);
    rs = rx_cnt; as = ab_cnt;
    tx_write(16'h00E1);
    frame_begin(1'b0, 1'b0, 4'd7);
    tx_write(16'h5A5A);
    spi_bits(8, 8, 16'h0096, 1'b0, got);
    frame_end();
    check("after_abort_rx", rx_log[rs % 64], 16'h0096);
    check("after_abort_count", rx_cnt - rs, 1);
    check("after_abort_miso", got, 16'h00E1);
    check("after_abort_no_abort", ab_cnt - as, 0);

    // Last sample edge coincides with cs rise
    rs = rx_cnt; as = ab_cnt; us = ur_cnt;
    tx_write(16'h00C7);
    frame_begin(1'b0, 1'b0, 4'd7);
    tx_write(16'h5A5A);
    spi_bits(8, 8, 16'h0042, 1'b1, got);
    wait_clk(3);
    sck = 1'b0;
    wait_clk(2);
    check("simul_rx_count", rx_cnt - rs, 1);
    check("simul_rx_data", rx_log[rs % 64], 16'h0042);
    check("simul_abort", ab_cnt - as, 0);
    check("simul_underrun", ur_cnt - us, 0);
    check("simul_miso", got, 16'h00C7);
    check("simul_busy", busy, 0);

    // Reset mid-frame with a word waiting in the holding buffer
    tx_write(16'h0033);
    frame_begin(1'b0, 1'b0, 4'd7);
    tx_write(16'h0077);
    spi_bits(8, 3, 16'h00FF, 1'b0, got);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_tx_ready", tx_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rx_data", rx_data, 0);
    check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_underrun", tx_underrun, 0);
    check("mid_rst_abort", frame_abort, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_miso", miso, 0);
    check("mid_rst_miso_oe", miso_oe, 1);
    @(negedge clk);
    cs  = 1'b1;
    sck = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(2);
    rs = rx_cnt; as = ab_cnt;
    tx_write(16'h006C);
    frame_begin(1'b0, 1'b0, 4'd7);
    tx_write(16'h5A5A);
    spi_bits(8, 8, 16'h0081, 1'b0, got);
    frame_end();
    check("post_rst_rx", rx_log[rs % 64], 16'h0081);
    check("post_rst_count", rx_cnt - rs, 1);
    check("post_rst_miso", got, 16'h006C);
    check("post_rst_abort", ab_cnt - as, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

SPI slave frame controller: it sequences one serial frame per word while chip-select is low. It shifts MOSI into a receive register and shifts a buffered transmit word out on MISO. Complete received words are delivered as single-cycle strobes. It instantiates `sck_detect` for CS/SCK edge events and sits between the synchronized SPI pins and the local register/bus logic.

## Interface
Parameters:
- `SPI_MAX_WIDTH_LOG`, 4: log2 of the maximum frame length; `DW = 2**SPI_MAX_WIDTH_LOG` is the data width (16 by default).

Ports:
- `clk` in 1: system clock; one clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpol` in 1: SCK idle level; static while `cs` is low.
- `cpha` in 1: 0 = sample on first edge, 1 = sample on second edge; static while `cs` is low.
- `spi_width` in `SPI_MAX_WIDTH_LOG`: frame length minus 1, so 0..DW-1 gives 1..DW bits; static while `cs` is low.
- `sck`, `cs`, `mosi` in 1 each: SPI pins, already synchronized to `clk`; `cs` is active low.
- `miso` out 1: serial output.
- `miso_oe` out 1: MISO output enable.
- `tx_data` in DW: word to transmit, right-aligned.
- `tx_valid` in 1, `tx_ready` out 1: transmit-buffer handshake.
- `rx_data` out DW: received word, right-aligned, upper bits zero.
- `rx_valid` out 1: one-cycle strobe marking `rx_data` valid.
- `tx_underrun` out 1: one-cycle pulse; a frame was loaded from an empty buffer.
- `frame_abort` out 1: one-cycle pulse; `cs` rose mid-frame.
- `busy` out 1: the controller is in a frame.

## Operation
- Edge roles: the sample edge is `sck_first_edge` when `cpha`=0 and `sck_second_edge` when `cpha`=1. The drive edge is the other one.
- States: IDLE and ACTIVE.
  - IDLE→ACTIVE on `spi_start`.
  - ACTIVE→IDLE on `spi_finish`.
  - `busy` = (state==ACTIVE).
- TX holding buffer (one entry, `tx_full` flag):
  - `tx_ready` = !`tx_full`.
  - `tx_valid && tx_ready` captures `tx_data` and sets `tx_full`.
- Load event: occurs on `spi_start` and on every word-completing sample.
  - `tx_sh` ← holding word if `tx_full`, and `tx_full` clears. Otherwise `tx_sh` ← 0 and `tx_underrun` pulses.
  - The load uses the buffer contents from before any same-cycle accept. A same-cycle accept sets `tx_full` with the new word.
- Sample edge in ACTIVE:
  - `rx_sh` ← {`rx_sh`[DW-2:0], `mosi`}.
  - `bit_cnt`++.
  - If `bit_cnt`==`spi_width`: `rx_data` ← new `rx_sh` masked to `spi_width`+1 bits, `rx_valid` pulses, `bit_cnt` ← 0, and the load event fires.
- Drive edge in ACTIVE: `tx_sh` shifts left by one only if `bit_cnt`≠0. This single rule covers both CPHA modes: the MSB stays on the line until the first sample of each word.
- `miso` = `tx_sh`[`spi_width`], MSB first.
- `miso_oe` = !`cs`. `miso` is driven 0 when `miso_oe` is low.
- Back-to-back words: while `cs` stays low, frames repeat with no gap.
- `spi_finish`:
  - If `bit_cnt`≠0, the partial word is discarded and `frame_abort` pulses.
  - `bit_cnt` ← 0.
  - The holding buffer is untouched.
- Simultaneous `spi_finish` and a word-completing sample: the word is delivered (`rx_valid`), then the controller goes to IDLE with no abort. The load event still fires.
- `spi_start` while ACTIVE cannot occur. It is ignored.

## Timing
- Reset values:
  - `miso`=0, `rx_data`=0, `rx_valid`=0, `tx_underrun`=0, `frame_abort`=0, `busy`=0.
  - `tx_ready`=1.
  - `miso_oe` follows `cs`.
  - Internal: `tx_full`=0, state=IDLE, `bit_cnt`=0, `tx_sh`=`rx_sh`=0.
- Event pulses are combinational from registered history: an edge is detected in the `clk` cycle where the pin value differs from last cycle's.
- Latencies:
  - `rx_valid`, `rx_data`, `tx_underrun` and `frame_abort` are registered. They assert one cycle after the detecting cycle.
  - `miso` updates one cycle after the drive-edge or load detection.
- Clock requirement: `clk` ≥ 4× SCK frequency, counting from the pins before external synchronization.
- Reset mid-frame: all state returns to reset values immediately. The bench must drop `cs` again to restart.

## Structure
- Shared package `spi_pkg`: state encoding (`ST_IDLE`, `ST_ACTIVE`) and the default `SPI_MAX_WIDTH_LOG`.
- Sub-module: `sck_detect`, parameterised with the same `SPI_MAX_WIDTH_LOG`. It supplies `spi_start`, `spi_finish`, `sck_first_edge` and `sck_second_edge`.
- Top level: the FSM, `bit_cnt`, `tx_sh`/`rx_sh`, the holding buffer and the output registers.

## Test plan
- Mode 0, width 8 (`cpol`=0, `cpha`=0, `spi_width`=7), `tx_data`=0xA5 preloaded, master sends 0x3C → `rx_data`=0x003C with one `rx_valid` pulse; master samples MISO as 0xA5; `tx_underrun`=0.
- Mode 3, width 16 (`cpol`=1, `cpha`=1, `spi_width`=15), two back-to-back words with `cs` held low; TX 0x1234 then 0xBEEF written after the first load → RX strobes carry master words 0xCAFE and 0x0F0F; MISO carries 0x1234 then 0xBEEF.
- Empty buffer at `cs` fall, width 4 → `tx_underrun` pulses once; MISO reads 0x0; RX is still correct.
- `cs` rises after 5 of 8 bits → `frame_abort` pulses; no `rx_valid`; the next full frame receives correctly.
- Last sample edge in the same cycle as `cs` rise → `rx_valid` pulses and `frame_abort` stays 0.
- `rst_n` pulsed low mid-frame → all outputs return to reset values; `tx_ready`=1; a subsequent frame works.
